// File: rtl/draw_sched_pkg.sv
// Shared types for the drawing scheduler: FSM states, the clear channel
// index and a saturating binary-to-BCD helper for the HEX displays.
package draw_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SCAN,
      S_DRAW,
      S_WAIT,
      S_OVER
   } state_t;

   localparam int CLEAR_ID = 0;

   // Two BCD digits; anything from 99 up shows as 99.
   function automatic logic [7:0] bcd_sat(input int unsigned v);
      if (v >= 99) return 8'h99;
      return {4'(v / 10), 4'(v % 10)};
   endfunction

endpackage

// File: rtl/shape_pick.sv
// Masked lowest-index priority encoder over the shape channels.
// Ports: active (per-channel flags), ptr (first index allowed),
//        found (some k >= ptr is active), id (lowest such k).
module shape_pick #(
   parameter int N    = 16,
   parameter int ID_W = 4
) (
   input  logic [N-1:0]    active,
   input  logic [ID_W:0]   ptr,
   output logic            found,
   output logic [ID_W-1:0] id
);

   // Channel 0 is the clear shape and never competes here.
   always_comb begin
      found = 1'b0;
      id    = '0;
      for (int k = N - 1; k >= 1; k--) begin
         if (active[k] && k >= int'(ptr)) begin
            found = 1'b1;
            id    = ID_W'(k);
         end
      end
   end

endmodule

// File: rtl/draw_scheduler.sv
// Frame drawing scheduler: clears, grants the pixel bus to each active shape
// in index order, handles start/death/restart and keeps BCD attempts/score.
// Ports: clock/resetn, game inputs (start_switch, god_mode, spike_hit,
//        frame_tick), per-channel shape_active/shape_gone/draw_done, packed
//        colour/x/y buses; outputs draw_start grant, shape_reset, VGA pixel,
//        cur_id, update_screen, frame_overrun, attempts_bcd, score_bcd.
module draw_scheduler
   import draw_sched_pkg::*;
#(
   parameter int NUM_SHAPES = 16,
   parameter int COORD_W    = 11,
   parameter int COLOUR_W   = 3,
   parameter int ID_W       = $clog2(NUM_SHAPES)
) (
   input  logic                           clock,
   input  logic                           resetn,
   input  logic                           start_switch,
   input  logic                           god_mode,
   input  logic                           spike_hit,
   input  logic                           frame_tick,
   input  logic [NUM_SHAPES-1:0]          shape_active,
   input  logic [NUM_SHAPES-1:0]          shape_gone,
   input  logic [NUM_SHAPES-1:0]          draw_done,
   input  logic [NUM_SHAPES*COLOUR_W-1:0] colour_bus,
   input  logic [NUM_SHAPES*COORD_W-1:0]  x_bus,
   input  logic [NUM_SHAPES*COORD_W-1:0]  y_bus,
   output logic [NUM_SHAPES-1:0]          draw_start,
   output logic                           shape_reset,
   output logic                           vga_enable,
   output logic [COLOUR_W-1:0]            vga_colour,
   output logic [COORD_W-1:0]             vga_x,
   output logic [COORD_W-1:0]             vga_y,
   output logic [ID_W-1:0]                cur_id,
   output logic                           update_screen,
   output logic                           frame_overrun,
   output logic [7:0]                     attempts_bcd,
   output logic [7:0]                     score_bcd
);

   localparam int CNT_W = $clog2(NUM_SHAPES + 1);
   localparam logic [NUM_SHAPES-1:0] ONE = NUM_SHAPES'(1);

   state_t           state;
   logic [ID_W:0]    ptr;
   logic             pending;
   logic [6:0]       att_cnt;
   logic [CNT_W-1:0] gone_cnt;
   logic             pick_found;
   logic [ID_W-1:0]  pick_id;
   logic             in_play;
   logic             abort;
   logic             tick_late;

   shape_pick #(
      .N    (NUM_SHAPES),
      .ID_W (ID_W)
   ) u_pick (
      .active (shape_active),
      .ptr    (ptr),
      .found  (pick_found),
      .id     (pick_id)
   );

   assign in_play = state inside {S_CLEAR, S_SCAN, S_DRAW, S_WAIT};
   assign abort   = (spike_hit & ~god_mode) | ~start_switch;

   // A tick that lands before the pass reaches WAIT is remembered, unless
   // the same cycle kills the player.
   assign tick_late = frame_tick & ~abort &
                      (state inside {S_CLEAR, S_SCAN, S_DRAW});

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state         <= S_IDLE;
         draw_start    <= '0;
         cur_id        <= '0;
         vga_enable    <= 1'b0;
         shape_reset   <= 1'b1;
         update_screen <= 1'b0;
         frame_overrun <= 1'b0;
         pending       <= 1'b0;
         ptr           <= '0;
         att_cnt       <= '0;
         gone_cnt      <= '0;
      end else begin
         update_screen <= 1'b0;
         gone_cnt      <= CNT_W'($countones(shape_gone));
         if (tick_late) begin
            pending       <= 1'b1;
            frame_overrun <= 1'b1;
         end
         if (in_play && abort) begin
            draw_start <= '0;
            cur_id     <= ID_W'(CLEAR_ID);
            state      <= S_OVER;
            if (att_cnt != 7'd99) att_cnt <= att_cnt + 7'd1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start_switch) begin
                     state       <= S_CLEAR;
                     shape_reset <= 1'b0;
                     vga_enable  <= 1'b1;
                     draw_start  <= ONE << CLEAR_ID;
                     cur_id      <= ID_W'(CLEAR_ID);
                  end
               end
               S_CLEAR: begin
                  if (draw_done[CLEAR_ID]) begin
                     draw_start <= '0;
                     ptr        <= (ID_W+1)'(1);
                     state      <= S_SCAN;
                  end
               end
               S_SCAN: begin
                  if (pick_found) begin
                     cur_id     <= pick_id;
                     draw_start <= ONE << pick_id;
                     state      <= S_DRAW;
                  end else begin
                     state <= S_WAIT;
                  end
               end
               S_DRAW: begin
                  if (draw_done[cur_id]) begin
                     draw_start <= '0;
                     ptr        <= {1'b0, cur_id} + (ID_W+1)'(1);
                     state      <= S_SCAN;
                  end
               end
               S_WAIT: begin
                  if (frame_tick || pending) begin
                     update_screen <= 1'b1;
                     pending       <= 1'b0;
                     draw_start    <= ONE << CLEAR_ID;
                     cur_id        <= ID_W'(CLEAR_ID);
                     state         <= S_CLEAR;
                  end
               end
               S_OVER: begin
                  // First cycle drops the grant, then a full clear runs.
                  if (!draw_start[CLEAR_ID]) begin
                     draw_start <= ONE << CLEAR_ID;
                  end else if (draw_done[CLEAR_ID]) begin
                     draw_start  <= '0;
                     vga_enable  <= 1'b0;
                     shape_reset <= 1'b1;
                     pending     <= 1'b0;
                     state       <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign vga_colour   = colour_bus[int'(cur_id)*COLOUR_W +: COLOUR_W];
   assign vga_x        = x_bus[int'(cur_id)*COORD_W +: COORD_W];
   assign vga_y        = y_bus[int'(cur_id)*COORD_W +: COORD_W];
   assign attempts_bcd = bcd_sat(32'(att_cnt));
   assign score_bcd    = bcd_sat(32'(gone_cnt));

endmodule
